ram32x4_arbiter: RTL and testbench
==================================

# ram32x4_arbiter

Shares one single-port 32x4 RAM (`ram32x4`: registered address/data/wren, unregistered q) between two requesters and provides a built-in clear sequencer that fills all 32 words with a given value. It sits between the RAM and its users, for example a switch/key-driven user port and a scanning display or VGA port. It owns every RAM control pin: requesters never drive the RAM directly.

## Interface
Parameters:
- ADDR_W, 5, RAM address width.
- DATA_W, 4, RAM word width.
- DEPTH, 32, number of words; must equal 2**ADDR_W.

Ports:
- clock  in  1  single system clock; all logic is on its rising edge.
- resetn  in  1  synchronous reset, active-low, sampled on the rising edge of `clock`.
- p0_req, p1_req  in  1  access request; held high until the matching gnt is seen.
- p0_we, p1_we  in  1  1 = write, 0 = read; held stable while req is high.
- p0_addr, p1_addr  in  ADDR_W  word address.
- p0_wdata, p1_wdata  in  DATA_W  write data.
- p0_gnt, p1_gnt  out  1  one-cycle grant pulse; the command is on the RAM pins in this cycle.
- p0_rvalid, p1_rvalid  out  1  one-cycle pulse; `rdata` is valid for that port's read.
- rdata  out  DATA_W  RAM q, passed through; meaningful only while an rvalid is high.
- clr_start  in  1  start a fill of all words; accepted only when the block is not clearing.
- clr_value  in  DATA_W  fill value; latched when `clr_start` is accepted.
- clr_busy  out  1  high while the fill writes are issued.
- clr_done  out  1  one-cycle pulse after the last fill write.
- ram_address  out  ADDR_W  to the RAM address input.
- ram_data  out  DATA_W  to the RAM data input.
- ram_wren  out  1  to the RAM write enable.
- ram_q  in  DATA_W  from the RAM q output.

## Operation
- FSM states:
  - SERVE: the arbitration state.
  - CLEAR: the fill state.
- SERVE:
  - Each cycle the block samples the requests. A port whose gnt is high in the current cycle is ineligible for that cycle.
  - If exactly one port is eligible, it wins.
  - If both are eligible, the winner is the port not recorded in `last_grant` (round robin). `last_grant` resets to port 1, so port 0 wins the first tie.
- A winner at edge E produces these registered outputs in cycle E+1:
  - px_gnt = 1.
  - ram_address = addr.
  - ram_wren = we.
  - ram_data = wdata.
  - `last_grant` updates to the winner.
- Read completion: px_rvalid = 1 in cycle E+2, with rdata = ram_q. Write completion: there is no completion pulse.
- With no winner, ram_wren = 0 and the address and data hold their last values.
- `clr_start` sampled high in SERVE:
  - Takes priority over any pending request; no grant is issued at that edge.
  - The block enters CLEAR.
  - The fill value is latched from `clr_value`.
- CLEAR:
  - Writes addresses 0 through DEPTH-1 in order, one per cycle, with ram_wren = 1 and ram_data = the latched value.
  - The edge after the write to address DEPTH-1 returns the block to SERVE.
  - While in CLEAR: no grants, requests wait, `clr_start` is ignored.
  - rvalid for a read granted just before CLEAR still fires on schedule.
- The address counter is ADDR_W bits wide and wraps from DEPTH-1 to 0. The wrap is the exit condition.

## Timing
- Reset values:
  - All gnt, rvalid, ram_wren, clr_busy and clr_done outputs are 0.
  - ram_address = 0, ram_data = 0.
  - The state is SERVE and `last_grant` = port 1.
- Reset mid-CLEAR: the block returns to SERVE next cycle with no further writes. Memory is left partially filled, and clr_done is not pulsed.
- Reset mid-read: a pending rvalid is cancelled.
- Request-to-grant latency is 1 cycle when uncontended.
- Grant-to-rvalid latency is 1 cycle.
- Throughput:
  - One RAM access per cycle overall.
  - A single continuously requesting port gets at most one grant every 2 cycles.
  - With both ports requesting continuously, grants alternate every cycle.
- CLEAR occupancy:
  - clr_busy is high for exactly DEPTH cycles: 32 cycles of ram_wren.
  - clr_done is high in the following cycle.
  - The first SERVE grant is possible in the clr_done cycle.

## Structure
- Shared package holds:
  - ADDR_W, DATA_W and DEPTH defaults.
  - Port index constants P0 = 0 and P1 = 1.
  - The state enum {SERVE, CLEAR}.
- Sub-module `rr_arbiter2`: combinational 2-way round-robin pick. Inputs are the eligible-request vector and `last_grant`; outputs are the winner and a valid flag.
- The top level holds the FSM, the clear counter, the registered RAM command and the rvalid pipeline.

## Test plan
- Uncontended write then read: p0 writes addr 5 = 4'hA.
  - Required: p0_gnt one cycle after the request, with ram_wren = 1 and ram_address = 5 in that cycle.
  - Then a p0 read of addr 5 gives p0_rvalid two cycles after its request, with rdata = 4'hA.
- Contention: p0 and p1 both request reads continuously from reset.
  - Required grant order: p0, p1, p0, p1.
  - Each rvalid lands one cycle after its gnt and carries that port's data.
- Clear: clr_value = 4'h7 and a clr_start pulse.
  - Required: clr_busy for 32 cycles covering addresses 0..31, then clr_done for 1 cycle.
  - Reads of addresses 0, 17 and 31 then return 4'h7.
- Clear versus request: p1_req and clr_start are raised in the same cycle.
  - Required: CLEAR is taken first and no p1_gnt is issued for 32 cycles.
  - p1_gnt arrives in the clr_done cycle.
- Reset mid-clear: resetn is driven low at fill address 10.
  - Required: next cycle, ram_wren = 0 and clr_busy = 0, with no clr_done pulse.
  - Address 3 reads 4'h7 and address 20 keeps its pre-clear value.
- Back-to-back clr_start during CLEAR is ignored. Required: exactly one clr_done pulse and exactly 32 writes.

Source files
------------

// File: rtl/ram32x4_arbiter_pkg.sv
// Shared constants and types for the 32x4 RAM arbiter and its round-robin picker.
package ram32x4_arbiter_pkg;

  localparam int RAM_ADDR_W = 5;
  localparam int RAM_DATA_W = 4;
  localparam int RAM_DEPTH  = 32;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  typedef enum logic {SERVE, CLEAR} state_t;

endpackage

// File: rtl/ram32x4_arbiter_rr.sv
// Combinational 2-way round-robin pick: on a tie the port not granted last time wins.
module rr_arbiter2
  import ram32x4_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = P0;
    if (req == 2'b11) winner = ~last_grant;
    else if (req[P1]) winner = P1;
  end

endmodule

// File: rtl/ram32x4_arbiter.sv
// Owns the single-port 32x4 RAM: arbitrates two requesters and runs a whole-memory fill.
//   state | meaning
//   SERVE | arbitrate requests, one registered RAM command per cycle
//   CLEAR | issue fill writes to addresses 0..DEPTH-1, requests wait
module ram32x4_arbiter
  import ram32x4_arbiter_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int DEPTH  = RAM_DEPTH
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] rdata,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_val;
  logic              last_grant;
  logic [1:0]        elig;
  logic              win, win_valid, grant;

  // A port being granted this cycle still holds req; it must not win again.
  assign elig  = {p1_req & ~p1_gnt, p0_req & ~p0_gnt};
  assign rdata = ram_q;

  rr_arbiter2 u_rr (
    .req        (elig),
    .last_grant (last_grant),
    .winner     (win),
    .valid      (win_valid)
  );

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      SERVE: begin
        if (clr_start) state_nxt = CLEAR;
        else           grant     = win_valid;
      end
      CLEAR: if (clr_cnt == LAST_ADDR) state_nxt = SERVE;
      default: state_nxt = SERVE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= SERVE;
      last_grant  <= P1;
      clr_cnt     <= '0;
      clr_val     <= '0;
      p0_gnt      <= 1'b0;
      p1_gnt      <= 1'b0;
      p0_rvalid   <= 1'b0;
      p1_rvalid   <= 1'b0;
      clr_busy    <= 1'b0;
      clr_done    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
    end else begin
      state     <= state_nxt;
      p0_gnt    <= grant && (win == P0);
      p1_gnt    <= grant && (win == P1);
      // A grant cycle carries the command, so wren tells read from write.
      p0_rvalid <= p0_gnt && !ram_wren;
      p1_rvalid <= p1_gnt && !ram_wren;
      clr_busy  <= (state == CLEAR);
      clr_done  <= clr_busy && (state == SERVE);

      if (state == SERVE && clr_start) begin
        clr_val <= clr_value;
        clr_cnt <= '0;
      end

      if (state == CLEAR) begin
        ram_address <= clr_cnt;
        ram_data    <= clr_val;
        ram_wren    <= 1'b1;
        clr_cnt     <= clr_cnt + 1'b1;
      end else if (grant) begin
        ram_address <= (win == P1) ? p1_addr  : p0_addr;
        ram_data    <= (win == P1) ? p1_wdata : p0_wdata;
        ram_wren    <= (win == P1) ? p1_we    : p0_we;
        last_grant  <= win;
      end else begin
        ram_wren <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram32x4_arbiter.sv
// Directed bench for ram32x4_arbiter with a behavioural ram32x4 (registered inputs, unregistered q).
module tb_ram32x4_arbiter;

  logic       clock = 1'b0;
  logic       resetn;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [4:0] p0_addr, p1_addr;
  logic [3:0] p0_wdata, p1_wdata;
  logic       p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [3:0] rdata;
  logic       clr_start;
  logic [3:0] clr_value;
  logic       clr_busy, clr_done;
  logic [4:0] ram_address;
  logic [3:0] ram_data;
  logic       ram_wren;
  logic [3:0] ram_q;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  ram32x4_arbiter dut (
    .clock(clock), .resetn(resetn),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .clr_start(clr_start), .clr_value(clr_value),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // RAM model; contents preset to mem[i] = i[3:0] on the first edge.
  logic [3:0] mem [32];
  logic [4:0] a_reg;
  logic       mem_loaded = 1'b0;
  always @(posedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 4'(i);
      mem_loaded <= 1'b1;
    end else if (ram_wren) begin
      mem[ram_address] <= ram_data;
    end
    a_reg <= ram_address;
  end
  assign ram_q = mem[a_reg];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One uncontended access: grant next cycle, rvalid the cycle after for reads.
  task automatic access(input string tag, input logic port, input logic we,
                        input logic [4:0] addr, input logic [3:0] wd, input logic [3:0] exp_rd);
    if (port) begin p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wd; end
    else      begin p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wd; end
    tick();
    check({tag, "_gnt"},  32'(port ? p1_gnt : p0_gnt), 32'd1);
    check({tag, "_wren"}, 32'(ram_wren), 32'(we));
    check({tag, "_addr"}, 32'(ram_address), 32'(addr));
    if (we) check({tag, "_wdata"}, 32'(ram_data), 32'(wd));
    p0_req = 0; p1_req = 0;
    tick();
    check({tag, "_rvalid"}, 32'(port ? p1_rvalid : p0_rvalid), 32'(!we));
    if (!we) check({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt, wr_cnt, done_cnt, order_err, align_err, gnt_idx, done_idx, rv_idx;
    logic [3:0] rv_data;
    logic [4:0] exp_addr;
    bit found;

    resetn = 0; clr_start = 0; clr_value = 0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    tick(); tick(); tick();
    check("rst_flags", 32'({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_wren, clr_busy, clr_done}), 32'd0);
    check("rst_addr", 32'(ram_address), 32'd0);
    check("rst_data", 32'(ram_data), 32'd0);
    resetn = 1;

    // Contention from reset: p0 reads 3, p1 reads 12, both held high.
    p0_req = 1; p0_we = 0; p0_addr = 5'd3;
    p1_req = 1; p1_we = 0; p1_addr = 5'd12;
    tick();
    check("cont1_gnt", 32'({p0_gnt, p1_gnt}), 32'b10);
    check("cont1_addr", 32'(ram_address), 32'd3);
    tick();
    check("cont2_gnt", 32'({p0_gnt, p1_gnt}), 32'b01);
    check("cont2_rv", 32'({p0_rvalid, p1_rvalid}), 32'b10);
    check("cont2_rdata", 32'(rdata), 32'h3);
    tick();
    check("cont3_gnt", 32'({p0_gnt, p1_gnt}), 32'b10);
    check("cont3_rv", 32'({p0_rvalid, p1_rvalid}), 32'b01);
    check("cont3_rdata", 32'(rdata), 32'hC);
    tick();
    check("cont4_gnt", 32'({p0_gnt, p1_gnt}), 32'b01);
    check("cont4_rv", 32'({p0_rvalid, p1_rvalid}), 32'b10);
    check("cont4_rdata", 32'(rdata), 32'h3);
    p0_req = 0; p1_req = 0;
    tick();
    check("cont5_gnt", 32'({p0_gnt, p1_gnt}), 32'b00);
    check("cont5_rv", 32'({p0_rvalid, p1_rvalid}), 32'b01);
    check("cont5_rdata", 32'(rdata), 32'hC);
    tick();

    // Uncontended write then read-back.
    access("wr5", 1'b0, 1'b1, 5'd5, 4'hA, 4'h0);
    access("rd5", 1'b0, 1'b0, 5'd5, 4'h0, 4'hA);

    // Clear and p1 read raised together: clear first, p1 granted in the clr_done cycle.
    clr_value = 4'h2; clr_start = 1;
    p1_req = 1; p1_we = 0; p1_addr = 5'd9;
    tick();
    clr_start = 0;
    check("cvr_s_gnt", 32'(p1_gnt), 32'd0);
    check("cvr_s_busy", 32'(clr_busy), 32'd0);
    busy_cnt = 0; gnt_idx = -1; done_idx = -1; rv_idx = -1; rv_data = 0;
    for (int k = 1; k <= 36; k++) begin
      tick();
      if (clr_busy) busy_cnt++;
      if (clr_done && done_idx < 0) done_idx = k;
      if (p1_rvalid && rv_idx < 0) begin rv_idx = k; rv_data = rdata; end
      if (p1_gnt && gnt_idx < 0) begin gnt_idx = k; p1_req = 0; end
    end
    p1_req = 0;
    check("cvr_busy_cnt", 32'(busy_cnt), 32'd32);
    check("cvr_done_idx", 32'(done_idx), 32'd33);
    check("cvr_gnt_idx", 32'(gnt_idx), 32'd33);
    check("cvr_rv_idx", 32'(rv_idx), 32'd34);
    check("cvr_rdata", 32'(rv_data), 32'h2);

    // Mark address 20, then reset partway through a fill.
    access("wr20", 1'b1, 1'b1, 5'd20, 4'h9, 4'h0);
    clr_value = 4'h7; clr_start = 1;
    tick();
    clr_start = 0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (ram_wren && ram_address == 5'd10) found = 1;
    end
    check("rmc_found_a10", 32'(found), 32'd1);
    resetn = 0;
    tick();
    resetn = 1;
    check("rmc_wren", 32'(ram_wren), 32'd0);
    check("rmc_busy", 32'(clr_busy), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (clr_done) done_cnt++;
      tick();
    end
    check("rmc_no_done", 32'(done_cnt), 32'd0);
    access("rmc_rd3", 1'b0, 1'b0, 5'd3, 4'h0, 4'h7);
    access("rmc_rd20", 1'b1, 1'b0, 5'd20, 4'h0, 4'h9);

    // Full fill with clr_start held through the first part of CLEAR.
    clr_value = 4'h7; clr_start = 1;
    tick();
    busy_cnt = 0; wr_cnt = 0; done_cnt = 0; order_err = 0; align_err = 0; exp_addr = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 10) clr_start = 0;
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      if (clr_busy != ram_wren) align_err++;
      if (ram_wren) begin
        wr_cnt++;
        if (ram_address != exp_addr || ram_data != 4'h7) order_err++;
        exp_addr = exp_addr + 5'd1;
      end
    end
    clr_start = 0;
    check("clr_busy_cnt", 32'(busy_cnt), 32'd32);
    check("clr_wr_cnt", 32'(wr_cnt), 32'd32);
    check("clr_done_cnt", 32'(done_cnt), 32'd1);
    check("clr_order", 32'(order_err), 32'd0);
    check("clr_align", 32'(align_err), 32'd0);
    access("clr_rd0", 1'b0, 1'b0, 5'd0, 4'h0, 4'h7);
    access("clr_rd17", 1'b1, 1'b0, 5'd17, 4'h0, 4'h7);
    access("clr_rd31", 1'b0, 1'b0, 5'd31, 4'h0, 4'h7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
